// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes bitstream words over valid/ready and shifts them
// into a logic-tile configuration chain, one bit per prog_clk cycle, framing
// exactly CHAIN_LEN shifts per load. The first bit shifted ends up at the tail.
// Optional feature macro: CCFF_READBACK_EN. When it is defined, the old chain
// contents arriving on ccff_tail are captured and presented on readback_word
// when the load completes.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 18,
    parameter int unsigned WORD_W    = 16
) (
    input  logic                             prog_clk,
    input  logic                             pReset,
    input  logic                             start,
    input  logic [WORD_W-1:0]                word_in,
    input  logic                             word_valid,
    output logic                             word_ready,
    output logic                             ccff_head,
    output logic                             config_enable,
    input  logic                             ccff_tail,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0]                readback_word,
    output logic                             readback_valid
`endif
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [WCNT_W-1:0]   wcnt;
    logic [31:0]         rem_bits_c;
    logic [WCNT_W-1:0]   load_bits_c;

    // Bits the next word contributes: a full word, or what is left of the chain.
    always_comb begin
        rem_bits_c  = 32'(CHAIN_LEN) - 32'(bit_count);
        load_bits_c = (rem_bits_c > 32'(WORD_W)) ? WCNT_W'(WORD_W) : WCNT_W'(rem_bits_c);
    end

    // Load sequencer: word handshake, serialisation and completion pulse.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state         <= IDLE;
            word_ready    <= 1'b0;
            ccff_head     <= 1'b0;
            config_enable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bit_count     <= '0;
            shreg         <= '0;
            wcnt          <= '0;
        end else begin
            done          <= 1'b0;
            config_enable <= 1'b0;
            case (state)
                IDLE: begin
                    ccff_head <= 1'b0;
                    if (start) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        bit_count  <= '0;
                        word_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    ccff_head <= 1'b0;
                    if (word_valid && word_ready) begin
                        shreg      <= word_in;
                        wcnt       <= load_bits_c;
                        word_ready <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    ccff_head     <= shreg[WORD_W-1];
                    config_enable <= 1'b1;
                    shreg         <= shreg << 1;
                    bit_count     <= bit_count + CNT_W'(1);
                    wcnt          <= wcnt - WCNT_W'(1);
                    if (wcnt == WCNT_W'(1)) begin
                        if (bit_count == CNT_W'(CHAIN_LEN - 1)) begin
                            state <= DONE;
                        end else begin
                            state      <= LOAD;
                            word_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    ccff_head <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] cap;
    logic [WORD_W-1:0] cap_next_c;

    // Tail bit enters the capture register on every edge that shifts the chain.
    assign cap_next_c = config_enable ? ((cap << 1) | WORD_W'(ccff_tail)) : cap;

    // Readback capture; cleared at start so short chains read zero-extended.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            cap            <= '0;
            readback_word  <= '0;
            readback_valid <= 1'b0;
        end else begin
            readback_valid <= 1'b0;
            if (state == IDLE && start) begin
                cap <= '0;
            end else begin
                cap <= cap_next_c;
            end
            if (state == DONE) begin
                readback_word  <= cap_next_c;
                readback_valid <= 1'b1;
            end
        end
    end
`else
    logic tail_unused;

    // Tail is not observed without readback.
    assign tail_unused = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: fixed scenarios plus randomized
// loads, compared against a bit-stream/latency model and a model of the chain.
module tb_ccff_chain_loader;

    localparam int unsigned CHAIN_LEN = 18;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              prog_clk   = 1'b0;
    logic              pReset     = 1'b1;
    logic              start      = 1'b0;
    logic [WORD_W-1:0] word_in    = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              ccff_head;
    logic              config_enable;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_count;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] readback_word;
    logic              readback_valid;
    logic [WORD_W-1:0] rb_at_done = '0;
`endif

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .ccff_head     (ccff_head),
        .config_enable (config_enable),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .bit_count     (bit_count)
`ifdef CCFF_READBACK_EN
        ,
        .readback_word (readback_word),
        .readback_valid(readback_valid)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [WORD_W-1:0]    ld_words [NWORDS];
    int                   ld_stall [NWORDS];
    logic                 exp_bits [CHAIN_LEN];
    logic [CHAIN_LEN-1:0] exp_vec  = '0;
    logic [CHAIN_LEN-1:0] obs_vec  = '0;
    logic [CHAIN_LEN-1:0] old_chain = '0;
    int  pos       = 0;
    bit  armed     = 1'b0;
    int  done_seen = 0;
    int  done_cyc  = 0;
    int  first_ce  = -1;
    int  start_cyc = 0;
    int  cyc       = 0;

    // Model of the driven chain: bit CHAIN_LEN-1 is the tail flop.
    logic [CHAIN_LEN-1:0] chain       = '0;
    logic                 preload_req = 1'b0;
    logic [CHAIN_LEN-1:0] preload_val = '0;

    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (preload_req)        chain <= preload_val;
        else if (config_enable) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end

    // Per-cycle compare against the expected bit stream.
    always @(negedge prog_clk) begin
        #1;
        if (!pReset) begin
            if (config_enable) begin
                if (!armed || pos >= int'(CHAIN_LEN)) begin
                    check("unexpected_shift", 1, 0);
                end else begin
                    if (pos == 0) first_ce = cyc;
                    check("ccff_head", ccff_head, exp_bits[pos]);
                    obs_vec[CHAIN_LEN-1-pos] = ccff_head;
                    pos++;
                    check("bit_count_shift", bit_count, pos);
                    check("busy_in_shift", busy, 1);
                end
            end else if (armed && !done) begin
                check("bit_count_hold", bit_count, pos);
            end
            if (!armed && !done) check("busy_idle", busy, 0);
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                check("done_armed", armed, 1);
                check("shift_total", pos, CHAIN_LEN);
                check("bit_count_done", bit_count, CHAIN_LEN);
                check("busy_at_done", busy, 0);
                check("head_at_done", ccff_head, 0);
`ifdef CCFF_READBACK_EN
                check("readback_valid_done", readback_valid, 1);
                check("readback_word", readback_word, WORD_W'(old_chain));
                rb_at_done = readback_word;
`endif
                armed = 1'b0;
            end
`ifdef CCFF_READBACK_EN
            else check("readback_valid_idle", readback_valid, 0);
`endif
        end
    end

    task automatic tick();
        @(negedge prog_clk);
    endtask

    task automatic build_model(output int exp_lat);
        exp_lat = 2;
        for (int k = 0; k < int'(NWORDS); k++) begin
            int rem;
            int b;
            rem = int'(CHAIN_LEN) - k * int'(WORD_W);
            b   = (rem > int'(WORD_W)) ? int'(WORD_W) : rem;
            exp_lat += 1 + ld_stall[k] + b;
            for (int j = 0; j < b; j++) begin
                exp_bits[k*int'(WORD_W)+j] = ld_words[k][int'(WORD_W)-1-j];
                exp_vec[int'(CHAIN_LEN)-1-(k*int'(WORD_W)+j)] = ld_words[k][int'(WORD_W)-1-j];
            end
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start     = 1'b0;
        start_cyc = cyc;
        pos       = 0;
        first_ce  = -1;
        done_seen = 0;
        old_chain = chain;
        armed     = 1'b1;
    endtask

    task automatic feed_word(input int k, input bit extra);
        int t;
        word_valid = 1'b0;
        if (ld_stall[k] == 0) begin
            word_in    = ld_words[k];
            word_valid = 1'b1;
        end else begin
            word_in = WORD_W'($urandom);
        end
        t = 0;
        while (word_ready !== 1'b1 && t < 100) begin
            start = extra && (t == 3);
            tick();
            t++;
        end
        start = 1'b0;
        check("ready_wait", word_ready, 1);
        repeat (ld_stall[k]) begin
            tick();
            check("stall_ce", config_enable, 0);
            check("stall_busy", busy, 1);
            check("stall_ready", word_ready, 1);
        end
        word_in    = ld_words[k];
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, output int lat);
        int t;
        t = 0;
        while (done_seen == 0 && t < 200) begin
            tick();
            #2;
            t++;
        end
        check("done_seen", done_seen, 1);
        lat = done_cyc - start_cyc + 1;
        check("done_latency", lat, exp_lat);
        check("first_ce_latency", first_ce - start_cyc, 2 + ld_stall[0]);
        check("chain_contents", chain, exp_vec);
        repeat (3) tick();
        #2;
        check("single_done", done_seen, 1);
        check("idle_after_done", busy, 0);
        check("ready_after_done", word_ready, 0);
    endtask

    task automatic run_load(input bit extra, output int lat);
        int exp_lat;
        build_model(exp_lat);
        start_load();
        for (int k = 0; k < int'(NWORDS); k++) feed_word(k, extra && (k == 1));
        wait_done(exp_lat, lat);
    endtask

    initial begin
        int lat;
        int t;

        // Reset, then idle with no start
        tick();
        tick();
        pReset = 1'b0;
        repeat (10) begin
            tick();
            check("idle_ready", word_ready, 0);
            check("idle_head", ccff_head, 0);
            check("idle_ce", config_enable, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_bit_count", bit_count, 0);
        end

        // Nominal load
        ld_words[0] = 16'hA5C3;
        ld_words[1] = 16'hC000;
        ld_stall[0] = 0;
        ld_stall[1] = 0;
        run_load(1'b0, lat);
        check("nominal_latency_literal", lat, 22);
        check("nominal_stream_literal", obs_vec, 18'h2970F);
        check("nominal_bit_count_literal", bit_count, 18);

        // Back-pressure on the second word
        ld_stall[1] = 5;
        run_load(1'b0, lat);
        check("backpressure_latency_literal", lat, 27);

        // start pulsed and word_valid held while shifting
        ld_words[0] = 16'h1234;
        ld_words[1] = 16'h8000;
        ld_stall[1] = 0;
        run_load(1'b1, lat);

        // Randomized loads
        for (int n = 0; n < 20; n++) begin
            bit extra;
            extra = 1'($urandom_range(0, 1));
            for (int k = 0; k < int'(NWORDS); k++) begin
                ld_words[k] = WORD_W'($urandom);
                ld_stall[k] = int'($urandom_range(0, 4));
            end
            run_load(extra, lat);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Reset after 7 shifted bits, with start coincident
        ld_words[0] = WORD_W'($urandom);
        ld_words[1] = WORD_W'($urandom);
        ld_stall[0] = 0;
        ld_stall[1] = 0;
        build_model(t);
        start_load();
        feed_word(0, 1'b0);
        t = 0;
        while (pos < 7 && t < 50) begin
            tick();
            #2;
            t++;
        end
        check("reached_7_bits", pos, 7);
        pReset = 1'b1;
        start  = 1'b1;
        tick();
        check("rst_ce", config_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_ready", word_ready, 0);
        check("rst_done", done, 0);
        check("rst_head", ccff_head, 0);
        armed  = 1'b0;
        pos    = 0;
        pReset = 1'b0;
        start  = 1'b0;
        repeat (4) begin
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_ce", config_enable, 0);
        end

        // Clean load after reset
        ld_words[0] = WORD_W'($urandom);
        ld_words[1] = WORD_W'($urandom);
        ld_stall[0] = 1;
        run_load(1'b0, lat);

`ifdef CCFF_READBACK_EN
        // Readback of a preloaded chain while loading all ones
        preload_val = 18'h2AAAA;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        ld_words[0] = '1;
        ld_words[1] = '1;
        ld_stall[0] = 0;
        ld_stall[1] = 0;
        run_load(1'b0, lat);
        check("readback_literal", rb_at_done, 16'hAAAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
